// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle between the timing generator and the TMDS encoder:
// sync/blank/pixel bytes in, three 10-bit TMDS symbols out.
interface tmds_encoder_if;
  logic            i_hsync;
  logic            i_vsync;
  logic            i_blank;
  logic [2:0][7:0] i_data;   // [0]=B, [1]=G, [2]=R
  logic [2:0][9:0] o_tmds;   // [0]=blue+sync, [1]=green, [2]=red; bit 0 sent first

  modport master (
    output i_hsync, i_vsync, i_blank, i_data,
    input  o_tmds
  );

  modport slave (
    input  i_hsync, i_vsync, i_blank, i_data,
    output o_tmds
  );
endinterface

// File: rtl/tmds_encoder.sv
// Three-channel DVI 1.0 TMDS encoder on the pixel clock.
// Pipeline: input capture -> transition minimisation (q_m) -> DC balance / control
// tokens. Inputs sampled at edge k appear on o_tmds after edge k+2.
module tmds_encoder #(
  parameter bit SYNC_INV = 1'b0   // 1 = timing source drives active-low syncs
) (
  input  logic           i_clk_pixel,
  input  logic           i_rst,
  tmds_encoder_if.slave  link
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  // ctrl is {C1, C0}; only channel 0 carries real sync values.
  typedef struct packed {
    logic       blank;
    logic [1:0] ctrl;
  } ctl_t;

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [4:0] cnt;
  } bal_t;

  ctl_t              in_ctl;
  ctl_t              s1_ctl;
  logic [2:0][7:0]   in_data;
  logic [2:0][8:0]   s1_qm;
  logic [2:0][9:0]   tmds_q;
  logic signed [4:0] cnt [3];
  bal_t              bal [3];

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimised 9-bit word; q_m[8]=1 marks the XOR chain.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // DC-balancing step: picks whether to invert q_m[7:0] from the running disparity.
  function automatic bal_t balance(input logic [8:0] qm, input logic signed [4:0] c);
    bal_t              r;
    logic signed [4:0] n1;
    logic signed [4:0] n0;
    logic signed [4:0] diff;
    n1   = signed'({1'b0, popcount8(qm[7:0])});
    n0   = 5'sd8 - n1;
    diff = n1 - n0;
    if ((c == 5'sd0) || (n1 == n0)) begin
      r.sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      r.cnt = qm[8] ? (c + diff) : (c - diff);
    end else if (((c > 5'sd0) && (n1 > n0)) || ((c < 5'sd0) && (n0 > n1))) begin
      r.sym = {1'b1, qm[8], ~qm[7:0]};
      r.cnt = c + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      r.sym = {1'b0, qm[8], qm[7:0]};
      r.cnt = c - (qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
    return r;
  endfunction

  function automatic logic [9:0] token(input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return TOKEN_00;
      2'b01:   return TOKEN_01;
      2'b10:   return TOKEN_10;
      default: return TOKEN_11;
    endcase
  endfunction

  // Capture sync/blank/pixels; reset parks the pipe in a blank, C1C0=00 period.
  // NOTE: registered state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      in_ctl  <= '{blank: 1'b1, ctrl: 2'b00};
      in_data <= '0;
    end else begin
      in_ctl.blank <= link.i_blank;
      in_ctl.ctrl  <= {link.i_vsync ^ SYNC_INV, link.i_hsync ^ SYNC_INV};
      in_data      <= link.i_data;
    end
  end

  // Stage 1: transition minimisation per channel, control travels alongside.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      s1_ctl <= '{blank: 1'b1, ctrl: 2'b00};
      s1_qm  <= '0;
    end else begin
      s1_ctl <= in_ctl;
      for (int ch = 0; ch < 3; ch++) s1_qm[ch] <= qm_encode(in_data[ch]);
    end
  end

  // Candidate balanced symbol and next disparity for each channel.
  // NOTE: every element is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) bal[ch] = balance(s1_qm[ch], cnt[ch]);
  end

  // Stage 2: emit control token (disparity cleared) or balanced data symbol.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        tmds_q[ch] <= TOKEN_00;
        cnt[ch]    <= '0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        if (s1_ctl.blank) begin
          tmds_q[ch] <= token((ch == 0) ? s1_ctl.ctrl : 2'b00);
          cnt[ch]    <= '0;
        end else begin
          tmds_q[ch] <= bal[ch].sym;
          cnt[ch]    <= bal[ch].cnt;
        end
      end
    end
  end

  assign link.o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: two instances (SYNC_INV=0 and 1) share stimulus; a reference
// model fills a scoreboard keyed by the cycle each symbol is due, a monitor compares.
module tb_tmds_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmds_encoder_if bus0();
  tmds_encoder_if bus1();

  tmds_encoder #(.SYNC_INV(1'b0)) dut0 (.i_clk_pixel(clk), .i_rst(rst), .link(bus0));
  tmds_encoder #(.SYNC_INV(1'b1)) dut1 (.i_clk_pixel(clk), .i_rst(rst), .link(bus1));

  typedef struct {
    int              due;
    bit              active;
    logic [2:0][7:0] d;
    logic [2:0][9:0] e0;
    logic [2:0][9:0] e1;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         m_cnt[3] = '{0, 0, 0};
  logic [9:0] tok[4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: transition minimisation from the DVI rules.
  function automatic logic [8:0] m_qm(input logic [7:0] d);
    int         ones = $countones(d);
    bit         xnor_mode = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    logic [8:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = xnor_mode ? 1'b0 : 1'b1;
    return q;
  endfunction

  // Reference: DC balance using plain integer disparity per channel.
  function automatic logic [9:0] m_balance(input int ch, input logic [8:0] qm);
    int         n1 = $countones(qm[7:0]);
    int         n0 = 8 - n1;
    int         c  = m_cnt[ch];
    logic [9:0] q;
    if (c == 0 || n1 == n0) begin
      if (qm[8]) begin q = {2'b01, qm[7:0]};  c = c + (n1 - n0); end
      else       begin q = {2'b10, ~qm[7:0]}; c = c + (n0 - n1); end
    end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      c = c + (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      c = c - (qm[8] ? 0 : 2) + (n1 - n0);
    end
    m_cnt[ch] = c;
    return q;
  endfunction

  // Receiver-side decode of a data symbol back to the pixel byte.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] v;
    logic [7:0] d;
    v    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return d;
  endfunction

  // One pixel-clock of stimulus; queues what both encoders must show 3 edges later.
  task automatic apply(input bit r, input bit b, input bit hs, input bit vs,
                       input logic [2:0][7:0] d);
    exp_t       e;
    logic [9:0] s;
    @(negedge clk);
    rst          = r;
    bus0.i_blank = b;  bus0.i_hsync = hs; bus0.i_vsync = vs; bus0.i_data = d;
    bus1.i_blank = b;  bus1.i_hsync = hs; bus1.i_vsync = vs; bus1.i_data = d;
    if (r) begin
      while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
      for (int k = 1; k <= 3; k++) begin
        e.due = cyc + k; e.active = 1'b0; e.d = '0;
        e.e0 = {3{10'h354}}; e.e1 = {3{10'h354}};
        sb.push_back(e);
      end
      m_cnt = '{0, 0, 0};
    end else begin
      e.due = cyc + 3; e.active = !b; e.d = d;
      if (b) begin
        m_cnt   = '{0, 0, 0};
        e.e0[0] = tok[{vs, hs}];
        e.e1[0] = tok[{~vs, ~hs}];
        for (int ch = 1; ch < 3; ch++) begin e.e0[ch] = 10'h354; e.e1[ch] = 10'h354; end
      end else begin
        for (int ch = 0; ch < 3; ch++) begin
          s = m_balance(ch, m_qm(d[ch]));
          e.e0[ch] = s; e.e1[ch] = s;
        end
      end
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the entry due this cycle and compares both encoders.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("late_entry", cyc, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("tmds", 32'(bus0.o_tmds), 32'(e.e0));
        check("tmds_sync_inv", 32'(bus1.o_tmds), 32'(e.e1));
        if (e.active)
          for (int ch = 0; ch < 3; ch++) check("decode", 32'(decode(bus0.o_tmds[ch])), 32'(e.d[ch]));
      end
    end
  end

  initial begin
    logic [2:0][7:0] rnd;
    bit              blank_now;
    int              run;
    bus0.i_blank = 1'b1; bus0.i_hsync = 1'b0; bus0.i_vsync = 1'b0; bus0.i_data = '0;
    bus1.i_blank = 1'b1; bus1.i_hsync = 1'b0; bus1.i_vsync = 1'b0; bus1.i_data = '0;

    // Reset held 3 cycles with arbitrary inputs.
    repeat (3) begin
      rnd = 24'($urandom());
      apply(1'b1, 1'($urandom()), 1'($urandom()), 1'($urandom()), rnd);
    end

    // Control tokens: vsync only, both syncs, hsync only, none.
    repeat (4) apply(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom()));
    repeat (2) apply(1'b0, 1'b1, 1'b1, 1'b1, 24'($urandom()));
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom()));
    apply(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom()));

    // Zero pixels from cnt=0: 100, 3FF, 100.
    repeat (3) apply(1'b0, 1'b0, 1'b1, 1'b1, '0);

    // One blank cycle clears disparity: next zero pixel is 100 again.
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset pulse mid active line, then active pixels resume from cnt=0.
    repeat (5) apply(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom()));
    apply(1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom()));
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom()));

    // Random pixels with random active/blank run lengths.
    blank_now = 1'b0;
    run       = 0;
    for (int i = 0; i < 20000; i++) begin
      if (run == 0) begin
        blank_now = !blank_now;
        run = blank_now ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 80));
      end
      run--;
      apply(1'b0, blank_now, 1'($urandom()), 1'($urandom()), 24'($urandom()));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
